grid_stream_framer: RTL and testbench

- Upstream front end for the day-4 `solver`.
- Accepts the raw puzzle byte stream (file or UART bytes, possibly CRLF, possibly missing the final newline) and produces a clean stream on the solver's `char_in`/`valid_in` interface.
- Normalises line endings and measures grid width/height.
- After end-of-file, appends the terminating newline and flush rows of '.' so the solver's line buffers drain without any bench-side padding.

---
 rtl/grid_stream_framer.sv | 178 +++++++++++++++++
 tb/tb_grid_stream_framer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_stream_framer.sv
// grid_stream_framer
//   Front end for the grid solver. Cleans a raw puzzle byte stream (CRLF or LF
//   line endings, optional missing final newline, stray bytes) into a stream of
//   '@' / '.' / '\n' on the solver's char_in/valid_in interface. It measures the
//   grid width and height. After end-of-file it appends the missing newline,
//   then FLUSH_ROWS rows of '.', so the solver's line buffers drain.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   byte_in/byte_valid  raw input byte, transferred when byte_ready is also high
//   byte_ready          high only while passing input through
//   eof_in              one-cycle end-of-input pulse (may coincide with last byte)
//   char_out/valid_out  registered output character, no backpressure
//   width_out           length of the first data row (0 until first newline)
//   height_out          data rows emitted (flush rows excluded)
//   done                sticky, flush finished
//   err_len             sticky, row length mismatch or row longer than MAX_WIDTH
//   err_char            sticky, byte other than '@' '.' CR LF seen
module grid_stream_framer #(
   parameter int FLUSH_ROWS = 2,
   parameter int MAX_WIDTH  = 1024,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   input  logic             eof_in,
   output logic [7:0]       char_out,
   output logic             valid_out,
   output logic [CNT_W-1:0] width_out,
   output logic [CNT_W-1:0] height_out,
   output logic             done,
   output logic             err_len,
   output logic             err_char
);

   localparam logic [7:0]       LF        = 8'h0A;
   localparam logic [7:0]       CR        = 8'h0D;
   localparam logic [7:0]       DOT       = 8'h2E;
   localparam logic [7:0]       ROCK      = 8'h40;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] MAX_COL   = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0] ROWS_INIT = CNT_W'(FLUSH_ROWS);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   typedef enum logic [2:0] {PASS, TERM, FLUSH_DOT, FLUSH_NL, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] rows_q, rows_d;
   logic [CNT_W-1:0] dot_q, dot_d;
   logic [CNT_W-1:0] width_d, height_d;
   logic [7:0]       char_d;
   logic             valid_d, done_d, err_len_d, err_char_d;
   logic             accept, illegal;
   logic [CNT_W-1:0] nl_width, nl_height;
   logic             nl_err;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + ONE;
   endfunction

   assign byte_ready = (state_q == PASS);
   assign accept     = byte_valid && byte_ready;
   assign illegal    = !(byte_in == ROCK || byte_in == DOT);

   // Effect of ending the current row, shared by a received '\n' and TERM.
   // The first row (height still 0) defines the width; later rows are checked.
   assign nl_width  = (height_out == '0) ? col_q : width_out;
   assign nl_err    = (height_out != '0) && (col_q != width_out);
   assign nl_height = sat_inc(height_out);

   always_comb begin
      state_d    = state_q;
      char_d     = 8'h00;
      valid_d    = 1'b0;
      col_d      = col_q;
      rows_d     = rows_q;
      dot_d      = dot_q;
      width_d    = width_out;
      height_d   = height_out;
      done_d     = done;
      err_len_d  = err_len;
      err_char_d = err_char;
      case (state_q)
         PASS: begin
            if (accept) begin
               if (byte_in == LF) begin
                  // Blank lines (column 0) vanish.
                  if (col_q != '0) begin
                     char_d    = LF;
                     valid_d   = 1'b1;
                     width_d   = nl_width;
                     height_d  = nl_height;
                     err_len_d = err_len | nl_err;
                     col_d     = '0;
                  end
               end else if (byte_in != CR) begin
                  if (illegal) err_char_d = 1'b1;
                  if (col_q >= MAX_COL) begin
                     err_len_d = 1'b1;
                  end else begin
                     char_d  = illegal ? DOT : byte_in;
                     valid_d = 1'b1;
                     col_d   = sat_inc(col_q);
                  end
               end
            end
            // A byte arriving with eof is folded in first, so decide on the
            // post-byte column/height.
            if (eof_in) begin
               rows_d = ROWS_INIT;
               dot_d  = '0;
               if (col_d != '0)                              state_d = TERM;
               else if (height_d != '0 && FLUSH_ROWS != 0)   state_d = FLUSH_DOT;
               else                                          state_d = DONE;
            end
         end
         TERM: begin
            char_d    = LF;
            valid_d   = 1'b1;
            width_d   = nl_width;
            height_d  = nl_height;
            err_len_d = err_len | nl_err;
            col_d     = '0;
            state_d   = (FLUSH_ROWS == 0) ? DONE : FLUSH_DOT;
         end
         FLUSH_DOT: begin
            char_d  = DOT;
            valid_d = 1'b1;
            dot_d   = dot_q + ONE;
            if (dot_d >= width_out) state_d = FLUSH_NL;
         end
         FLUSH_NL: begin
            char_d  = LF;
            valid_d = 1'b1;
            dot_d   = '0;
            rows_d  = rows_q - ONE;
            state_d = (rows_q > ONE) ? FLUSH_DOT : DONE;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: state_d = PASS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= PASS;
         char_out   <= 8'h00;
         valid_out  <= 1'b0;
         col_q      <= '0;
         rows_q     <= '0;
         dot_q      <= '0;
         width_out  <= '0;
         height_out <= '0;
         done       <= 1'b0;
         err_len    <= 1'b0;
         err_char   <= 1'b0;
      end else begin
         state_q    <= state_d;
         char_out   <= char_d;
         valid_out  <= valid_d;
         col_q      <= col_d;
         rows_q     <= rows_d;
         dot_q      <= dot_d;
         width_out  <= width_d;
         height_out <= height_d;
         done       <= done_d;
         err_len    <= err_len_d;
         err_char   <= err_char_d;
      end
   end

endmodule

// File: tb/tb_grid_stream_framer.sv
// Testbench for grid_stream_framer: directed vector table, hand-written
// latency/reset sequences, and random streams against a row-level model.
module tb_grid_stream_framer;

   localparam int FLUSH_ROWS = 2;
   localparam int MAX_WIDTH  = 1024;
   localparam int CNT_W      = 16;

   typedef logic [7:0] u8;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             eof_in;
   logic [7:0]       char_out;
   logic             valid_out;
   logic [CNT_W-1:0] width_out;
   logic [CNT_W-1:0] height_out;
   logic             done;
   logic             err_len;
   logic             err_char;

   always #5 clk = ~clk;

   grid_stream_framer #(
      .FLUSH_ROWS(FLUSH_ROWS),
      .MAX_WIDTH (MAX_WIDTH),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .byte_in   (byte_in),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .eof_in    (eof_in),
      .char_out  (char_out),
      .valid_out (valid_out),
      .width_out (width_out),
      .height_out(height_out),
      .done      (done),
      .err_len   (err_len),
      .err_char  (err_char)
   );

   int n_tests = 0;
   int n_fail  = 0;

   u8  got[$];
   bit collect = 1'b0;

   always @(negedge clk) if (collect && valid_out) got.push_back(char_out);

   function automatic string vis(input string s);
      string r = "";
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == 8'h0A) r = {r, "|"};
         else if (s[i] < 8'h20 || s[i] > 8'h7E) r = {r, "?"};
         else r = $sformatf("%s%c", r, s[i]);
      end
      return r;
   endfunction

   function automatic string q2s(input u8 q[$]);
      string r = "";
      foreach (q[i]) r = $sformatf("%s%c", r, q[i]);
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got \"%s\", expected \"%s\"", name, vis(act), vis(exp));
      end
   endtask

   task automatic do_reset;
      reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; eof_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Drives one stream with random idle gaps, then eof (on the last byte when
   // eol is set). Counts edges after the eof edge until done is seen, while
   // throwing junk bytes/eof pulses that must be ignored.
   task automatic run(input string s, input bit eol, output string out, output int lat);
      got.delete();
      collect = 1'b1;
      for (int i = 0; i < s.len(); i++) begin
         if ($urandom_range(0, 3) == 0) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
         end
         byte_valid = 1'b1;
         byte_in    = s[i];
         eof_in     = eol && (i == s.len() - 1);
         @(posedge clk); #1;
         byte_valid = 1'b0;
         eof_in     = 1'b0;
      end
      if (!eol || s.len() == 0) begin
         eof_in = 1'b1;
         @(posedge clk); #1;
         eof_in = 1'b0;
      end
      lat = 0;
      while (!done && lat < 4000) begin
         byte_valid = 1'($urandom_range(0, 1));
         byte_in    = 8'($urandom_range(0, 255));
         eof_in     = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      byte_valid = 1'b0;
      eof_in     = 1'b0;
      if (!done) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
      collect = 1'b0;
      out = q2s(got);
   endtask

   // Row-level model: splits the stream into rows on '\n' (end of file acts as
   // a final '\n'), drops CR and empty rows, maps bytes, then appends flush.
   task automatic model(input string s, output string exp, output int w, output int h,
                        output bit el, output bit ec, output int tail);
      u8 cur[$];
      u8 c;
      exp = ""; w = 0; h = 0; el = 0; ec = 0; tail = 0;
      for (int i = 0; i <= s.len(); i++) begin
         c = (i == s.len()) ? 8'h0A : u8'(s[i]);
         if (c == 8'h0D) continue;
         if (c == 8'h0A) begin
            if (cur.size() > 0) begin
               if (i == s.len()) tail = 1;
               if (h == 0) w = cur.size();
               else if (cur.size() != w) el = 1;
               foreach (cur[k]) exp = $sformatf("%s%c", exp, cur[k]);
               exp = {exp, "\n"};
               h++;
               cur.delete();
            end
            continue;
         end
         if (c != 8'h40 && c != 8'h2E) ec = 1;
         if (cur.size() >= MAX_WIDTH) el = 1;
         else cur.push_back((c == 8'h40) ? 8'h40 : 8'h2E);
      end
      if (h > 0) begin
         for (int r = 0; r < FLUSH_ROWS; r++) begin
            for (int k = 0; k < w; k++) exp = {exp, "."};
            exp = {exp, "\n"};
         end
         tail += FLUSH_ROWS * (w + 1);
      end
   endtask

   task automatic check_run(input string tag, input string s, input bit eol, input string exp,
                            input int w, input int h, input bit el, input bit ec, input int lat_exp);
      string out;
      int    lat;
      run(s, eol, out, lat);
      chk_s({tag, " stream"}, out, exp);
      chk({tag, " width"}, width_out, w);
      chk({tag, " height"}, height_out, h);
      chk({tag, " err_len"}, err_len, el);
      chk({tag, " err_char"}, err_char, ec);
      chk({tag, " done_latency"}, lat, lat_exp);
      do_reset();
   endtask

   typedef struct {
      string s;
      bit    eol;
      string exp;
      int    w;
      int    h;
      bit    el;
      bit    ec;
      int    lat;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{"..@\n@@@\n.@.\n", 1'b0, "..@\n@@@\n.@.\n...\n...\n", 3, 3, 1'b0, 1'b0, 9};
      tbl[1] = '{"..@\n@@@\n.@.",   1'b1, "..@\n@@@\n.@.\n...\n...\n", 3, 3, 1'b0, 1'b0, 10};
      tbl[2] = '{"@.\015\n.@\015\n", 1'b0, "@.\n.@\n..\n..\n",          2, 2, 1'b0, 1'b0, 7};
      tbl[3] = '{"@@@\n@@\n",       1'b0, "@@@\n@@\n...\n...\n",       3, 2, 1'b1, 1'b0, 9};
      tbl[4] = '{"@x@\n\n\n@@@\n",  1'b0, "@.@\n@@@\n...\n...\n",      3, 2, 1'b0, 1'b1, 9};
      tbl[5] = '{"",                1'b0, "",                          0, 0, 1'b0, 1'b0, 1};
      tbl[6] = '{"\015\n@",         1'b1, "@\n.\n.\n",                 1, 1, 1'b0, 1'b0, 6};
      tbl[7] = '{"@@\n@@@",         1'b0, "@@\n@@@\n..\n..\n",         2, 2, 1'b1, 1'b0, 8};

      do_reset();

      // Reset state
      chk("rst valid_out", valid_out, 0);
      chk("rst char_out", char_out, 0);
      chk("rst width", width_out, 0);
      chk("rst height", height_out, 0);
      chk("rst done", done, 0);
      chk("rst err_len", err_len, 0);
      chk("rst err_char", err_char, 0);
      chk("rst byte_ready", byte_ready, 1);

      // One-cycle latency; CR produces nothing
      byte_valid = 1'b1; byte_in = 8'h40;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      chk("lat valid", valid_out, 1);
      chk("lat char", char_out, 8'h40);
      @(posedge clk); #1;
      chk("idle valid", valid_out, 0);
      chk("idle char", char_out, 0);
      byte_valid = 1'b1; byte_in = 8'h0D;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      chk("cr valid", valid_out, 0);
      do_reset();

      // Directed table
      foreach (tbl[i])
         check_run($sformatf("vec%0d", i), tbl[i].s, tbl[i].eol, tbl[i].exp,
                   tbl[i].w, tbl[i].h, tbl[i].el, tbl[i].ec, tbl[i].lat);

      // Reset in the middle of flushing
      begin
         string g = "@@@\n";
         for (int i = 0; i < g.len(); i++) begin
            byte_valid = 1'b1; byte_in = g[i];
            @(posedge clk); #1;
         end
         byte_valid = 1'b0;
         eof_in = 1'b1;
         @(posedge clk); #1;
         eof_in = 1'b0;
         @(posedge clk); #1;
         chk("flush_active valid", valid_out, 1);
         chk("flush_active char", char_out, 8'h2E);
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         chk("mid_rst valid", valid_out, 0);
         chk("mid_rst done", done, 0);
         chk("mid_rst width", width_out, 0);
         chk("mid_rst height", height_out, 0);
         chk("mid_rst byte_ready", byte_ready, 1);
         @(posedge clk); #1;
         chk("mid_rst quiet", valid_out, 0);
         check_run("after_rst", "@\n", 1'b0, "@\n.\n.\n", 1, 1, 1'b0, 1'b0, 5);
      end

      // Random streams against the model
      for (int t = 0; t < 30; t++) begin
         string s = "";
         string exp;
         int    nr = $urandom_range(0, 4);
         int    bw = $urandom_range(1, 5);
         int    w, h, tail;
         bit    el, ec, eol;
         for (int r = 0; r < nr; r++) begin
            int len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : bw;
            for (int c = 0; c < len; c++) begin
               int k = $urandom_range(0, 9);
               u8  ch = (k < 5) ? 8'h40 : (k < 9) ? 8'h2E : 8'h78;
               s = $sformatf("%s%c", s, ch);
            end
            if (r < nr - 1 || $urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 2) == 0) s = {s, "\015"};
               s = {s, "\n"};
               if ($urandom_range(0, 4) == 0) s = {s, "\n"};
            end
         end
         eol = 1'($urandom_range(0, 1));
         model(s, exp, w, h, el, ec, tail);
         check_run($sformatf("rnd%0d", t), s, eol, exp, w, h, el, ec, tail + 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
